// File: rtl/parking_meter_pkg.sv
// ---------------------------------------------------------------------------
// parking_meter_pkg
// Shared constants for the parking meter time-keeping core: saturation
// limit, per-button add amounts, switch reload values and the low-time
// threshold, plus the saturating clamp used by the meter update.
// ---------------------------------------------------------------------------
package parking_meter_pkg;

   localparam logic [15:0] METER_MAX  = 16'd9999;

   localparam logic [15:0] ADD_U      = 16'd50;
   localparam logic [15:0] ADD_L      = 16'd150;
   localparam logic [15:0] ADD_R      = 16'd200;
   localparam logic [15:0] ADD_D      = 16'd500;

   localparam logic [15:0] RELOAD_SW0 = 16'd10;
   localparam logic [15:0] RELOAD_SW1 = 16'd205;

   localparam logic [15:0] LOW_THRESH = 16'd200;

   // Clamp a 17-bit intermediate result to the displayable range.
   function automatic logic [15:0] sat_meter(input logic [16:0] v);
      if (v > {1'b0, METER_MAX}) begin
         sat_meter = METER_MAX;
      end else begin
         sat_meter = v[15:0];
      end
   endfunction

endpackage

// File: rtl/parking_meter_counter_edge_sync.sv
// ---------------------------------------------------------------------------
// edge_sync
// Two-flop synchronizer followed by a rising-edge detector. Produces a
// single-cycle pulse for each low-to-high transition of an asynchronous
// level input; holding the input high yields no further pulses.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset, clears all history
//   d_i     in   asynchronous level input
//   pulse_o out  one-cycle pulse on a synchronized rising edge
// ---------------------------------------------------------------------------
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic pulse_o
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= d_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   // Combinational pulse so the meter update lands one edge after the
   // second synchronizer stage. Because prev_q is cleared by reset, an
   // input still high when reset releases counts as a fresh press.
   assign pulse_o = s2_q & ~prev_q;

endmodule

// File: rtl/parking_meter_counter.sv
// ---------------------------------------------------------------------------
// parking_meter_counter
// Time-keeping core of the parking meter. Converts add-time buttons and
// reload switches into a binary seconds-remaining value (0..9999) that
// decrements once per meter second, and produces the blink phase and
// low-time / expired status flags for the display controller.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   btnU/L/R/D in   add 50/150/200/500 s (debounced levels)
//   sw0, sw1   in   rising edge reloads meter to 10 s / 205 s
//   meter_data out  seconds remaining, binary
//   second     out  high during the first half of each meter second
//   below200   out  meter_data < 200
//   is0        out  meter_data == 0
// ---------------------------------------------------------------------------
module parking_meter_counter
   import parking_meter_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btnU,
   input  logic        btnL,
   input  logic        btnR,
   input  logic        btnD,
   input  logic        sw0,
   input  logic        sw1,
   output logic [15:0] meter_data,
   output logic        second,
   output logic        below200,
   output logic        is0
);

   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_SEC - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(TICKS_PER_SEC / 2);

   // Bit order: 0=U 1=L 2=R 3=D 4=sw0 5=sw1
   logic [5:0] raw;
   logic [5:0] pulse;

   assign raw = {sw1, sw0, btnD, btnR, btnL, btnU};

   for (genvar g = 0; g < 6; g++) begin : g_sync
      edge_sync u_edge_sync (
         .clk     (clk),
         .rst     (rst),
         .d_i     (raw[g]),
         .pulse_o (pulse[g])
      );
   end

   logic [CW-1:0] cnt_q,      cnt_d;
   logic [15:0]   meter_q,    meter_d;
   logic          second_q,   second_d;
   logic          below200_q, below200_d;
   logic          is0_q,      is0_d;

   logic          tick;
   logic          dec;
   logic [15:0]   add;
   logic [16:0]   sum;

   assign tick = (cnt_q == CNT_LAST);

   always_comb begin
      add        = '0;
      dec        = 1'b0;
      sum        = '0;
      meter_d    = meter_q;
      cnt_d      = cnt_q;

      // Only the highest-priority button pulse is honoured in a cycle.
      if      (pulse[0]) add = ADD_U;
      else if (pulse[1]) add = ADD_L;
      else if (pulse[2]) add = ADD_R;
      else if (pulse[3]) add = ADD_D;

      if (pulse[5]) begin
         meter_d = RELOAD_SW1;
         cnt_d   = '0;
      end else if (pulse[4]) begin
         meter_d = RELOAD_SW0;
         cnt_d   = '0;
      end else begin
         // Decrement decision uses the old value, so an add arriving on a
         // tick at zero is not reduced. No underflow is possible.
         dec     = tick && (meter_q != 16'd0);
         sum     = {1'b0, meter_q} + {1'b0, add} - {16'd0, dec};
         meter_d = sat_meter(sum);
         cnt_d   = tick ? '0 : cnt_q + CW'(1);
      end

      second_d   = (cnt_d < CNT_HALF);
      below200_d = (meter_d < LOW_THRESH);
      is0_d      = (meter_d == 16'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         meter_q    <= '0;
         second_q   <= 1'b1;
         below200_q <= 1'b1;
         is0_q      <= 1'b1;
      end else begin
         cnt_q      <= cnt_d;
         meter_q    <= meter_d;
         second_q   <= second_d;
         below200_q <= below200_d;
         is0_q      <= is0_d;
      end
   end

   assign meter_data = meter_q;
   assign second     = second_q;
   assign below200   = below200_q;
   assign is0        = is0_q;

endmodule

// File: doc/parking_meter_counter.md
# parking_meter_counter

Time-keeping core of the parking meter. It converts the four add-time buttons and two reload switches into a binary seconds-remaining value (0–9999) and decrements it once per second. It also produces the `second`, `below200` and `is0` status signals. It sits directly upstream of `DisplayController`, driving that block's `meter_data`, `second`, `below200` and `is0` inputs.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100_000_000: `clk` cycles per meter second; the bench uses 10.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `btnU`  in  1  button, adds 50 s; asynchronous level, debounced externally.
- `btnL`  in  1  button, adds 150 s.
- `btnR`  in  1  button, adds 200 s.
- `btnD`  in  1  button, adds 500 s.
- `sw0`  in  1  switch; a rising edge reloads the meter to 10 s.
- `sw1`  in  1  switch; a rising edge reloads the meter to 205 s.
- `meter_data`  out  16  seconds remaining, binary, 0–9999.
- `second`  out  1  blink phase: high during the first half of each meter second.
- `below200`  out  1  `meter_data < 200`.
- `is0`  out  1  `meter_data == 0`.

## Operation
- Input conditioning:
  - Each of the six inputs passes through a 2-FF synchronizer and then a rising-edge detector.
  - This gives one single-cycle pulse per press. Holding an input produces no further pulses.
- Prescaler:
  - `cnt` counts 0..TICKS_PER_SEC−1 and wraps to 0.
  - `tick` is asserted when `cnt == TICKS_PER_SEC−1`.
- Per-cycle update, in priority order (the first matching rule applies):
  1. `rst` → meter 0, `cnt` 0.
  2. `sw1` pulse → meter 205, `cnt` 0.
  3. `sw0` pulse → meter 10, `cnt` 0. If `sw1` and `sw0` pulse together, 205 wins.
  4. Otherwise: `next = min(9999, v + add − dec)`, where:
     - `add` comes from the single highest-priority button pulse, in order U(50) > L(150) > R(200) > D(500). Lower-priority pulses in the same cycle are discarded, not queued.
     - `dec = tick && (v != 0)`. The check uses the old value `v`, so an add that coincides with a tick at v = 0 is not decremented.
- Arithmetic:
  - Computed in 17 bits and then saturated to 9999.
  - The value never wraps below 0 or above 9999.
- A reload restarts the prescaler, so the first decrement after a reload happens exactly TICKS_PER_SEC cycles later.
- Adds do not touch the prescaler.

## Timing
- Reset values: `meter_data` 0, `is0` 1, `below200` 1, `second` 1, `cnt` 0, all synchronizer and edge flops 0.
- Reset asserts immediately, without a clock edge.
- All outputs are registered:
  - `below200` and `is0` are derived from the next value and therefore change in the same cycle as `meter_data`.
  - `second` is registered from `cnt_next < TICKS_PER_SEC/2`.
- Latency: an input first sampled high at edge n produces its `meter_data` update at edge n+2, visible after the third edge (2 synchronizer stages plus 1 update stage).
- Steady countdown: `meter_data` decrements once every TICKS_PER_SEC cycles. `second` falls at `cnt` = TICKS_PER_SEC/2 and rises when `cnt` wraps to 0.
- If reset is asserted mid-press, the edge history is cleared. An input that is still high when reset is released registers as a new press.

## Structure
- Shared package `parking_meter_pkg` holds:
  - `METER_MAX = 9999`
  - `ADD_U = 50`, `ADD_L = 150`, `ADD_R = 200`, `ADD_D = 500`
  - `RELOAD_SW0 = 10`, `RELOAD_SW1 = 205`
  - `LOW_THRESH = 200`
- Sub-module `edge_sync` (2-FF synchronizer plus rising-edge pulse, with `clk` and `rst`) is instantiated six times.
- The prescaler, priority/saturating update and output registers live in the top module.

## Test plan
Bench runs with TICKS_PER_SEC = 10.
1. Pulse `rst` mid-run without a clock → outputs go to 0/1/1/1 at once. Run 50 cycles → `meter_data` stays 0, no underflow.
2. Hold `btnU` for 30 cycles from the idle-0 state → `meter_data` 50 exactly three edges after the first sample, single add only. Ten cycles later → 49.
3. Pulse `sw1` → 205, `below200` 0. After 6 ticks (60 cycles) → 199, with `below200` rising in the same cycle.
4. Pulse `btnD` 21 times from 205 → value saturates at 9999. Then pulse `btnL` → stays 9999. Next tick → 9998.
5. Pulse `btnU` and `btnD` in the same cycle from 0 → +50 only. Pulse `sw0` and `sw1` in the same cycle → 205, and the first decrement occurs exactly 10 cycles later.
6. At value 0, time a `btnR` pulse to land on a tick cycle → `meter_data` 200, not 199. `is0` falls and `below200` falls in that cycle.
